// File: rtl/p405s_itlb_nway.sv
// Instruction shadow TLB: N-entry fully associative EPN->RPN cache with UTLB refill on miss.
// Latency: hit / real-mode result 1 cycle after lkValid; miss result 1 cycle after the fill write (REPLAY).
// Backpressure: lkBusy high outside IDLE; lkValid is ignored while busy; fillReq held until fillAck or cancel.
//
// Ports:
//   CB, resetCore                       clock, synchronous active-high reset
//   lkValid/lkEPN/msrIR/real{E,I,U0}    lookup request and real-mode attributes
//   isAbort, isInvalidate               cancel outstanding miss, flash-invalidate
//   lkBusy/lkRdy/lkRA/lkE/lkI/lkU0      lookup status and result (result valid with lkRdy)
//   itlbMiss, lkFault                   one-cycle miss / no-mapping pulses
//   fillReq/fillEPN                     refill request to the UTLB
//   fillAck/fillNoMap/fillRPN/fillSize/fill{E,I,U0}  refill response
module p405s_itlb_nway #(
    parameter int ENTRIES = 4,
    parameter int EPN_W   = 22,
    parameter int RPN_W   = 22
) (
    input  logic             CB,
    input  logic             resetCore,
    input  logic             lkValid,
    input  logic [EPN_W-1:0] lkEPN,
    input  logic             msrIR,
    input  logic             realE,
    input  logic             realI,
    input  logic             realU0,
    input  logic             isAbort,
    input  logic             isInvalidate,
    output logic             lkBusy,
    output logic             lkRdy,
    output logic [RPN_W-1:0] lkRA,
    output logic             lkE,
    output logic             lkI,
    output logic             lkU0,
    output logic             itlbMiss,
    output logic             lkFault,
    output logic             fillReq,
    output logic [EPN_W-1:0] fillEPN,
    input  logic             fillAck,
    input  logic             fillNoMap,
    input  logic             fillE,
    input  logic             fillI,
    input  logic             fillU0,
    input  logic [RPN_W-1:0] fillRPN,
    input  logic [2:0]       fillSize
);

    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_REPLAY} state_t;

    // Ones in every EPN bit that participates in the compare for page size s.
    function automatic logic [EPN_W-1:0] cmp_mask(input logic [2:0] s);
        logic [EPN_W-1:0] m;
        for (int b = 0; b < EPN_W; b++) m[b] = (b >= 2 * int'(s));
        return m;
    endfunction

    // RPN with its in-page offset bits taken from the effective address.
    function automatic logic [RPN_W-1:0] merge_ra(input logic [RPN_W-1:0] rpn,
                                                  input logic [EPN_W-1:0] epn,
                                                  input logic [2:0]       s);
        logic [RPN_W-1:0] low;
        logic [RPN_W-1:0] ea_r;
        ea_r = RPN_W'(epn);
        for (int b = 0; b < RPN_W; b++) low[b] = (b < 2 * int'(s));
        return (rpn & ~low) | (ea_r & low);
    endfunction

    state_t               state_q, state_d;
    logic [ENTRIES-1:0]   vld_q, vld_d;
    logic [EPN_W-1:0]     epn_q  [ENTRIES];
    logic [EPN_W-1:0]     epn_d  [ENTRIES];
    logic [RPN_W-1:0]     rpn_q  [ENTRIES];
    logic [RPN_W-1:0]     rpn_d  [ENTRIES];
    logic [2:0]           size_q [ENTRIES];
    logic [2:0]           size_d [ENTRIES];
    logic [ENTRIES-1:0]   e_q, e_d, i_q, i_d, u0_q, u0_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;

    logic                 lk_rdy_q, lk_rdy_d;
    logic [RPN_W-1:0]     lk_ra_q, lk_ra_d;
    logic                 lk_e_q, lk_e_d, lk_i_q, lk_i_d, lk_u0_q, lk_u0_d;
    logic                 itlb_miss_q, itlb_miss_d;
    logic                 lk_fault_q, lk_fault_d;
    logic                 fill_req_q, fill_req_d;
    logic [EPN_W-1:0]     fill_epn_q, fill_epn_d;

    logic                 hit;
    logic [IDX_W-1:0]     hit_idx;
    logic                 has_inv;
    logic [IDX_W-1:0]     inv_idx;
    logic [IDX_W-1:0]     victim;

    // Associative compare; scanning downward leaves the lowest matching index.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        has_inv = 1'b0;
        inv_idx = '0;
        for (int k = ENTRIES - 1; k >= 0; k--) begin
            if (vld_q[k] && (((epn_q[k] ^ lkEPN) & cmp_mask(size_q[k])) == '0)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
            end
            if (!vld_q[k]) begin
                has_inv = 1'b1;
                inv_idx = IDX_W'(k);
            end
        end
        victim = has_inv ? inv_idx : ptr_q;
    end

    always_comb begin
        state_d     = state_q;
        vld_d       = vld_q;
        epn_d       = epn_q;
        rpn_d       = rpn_q;
        size_d      = size_q;
        e_d         = e_q;
        i_d         = i_q;
        u0_d        = u0_q;
        ptr_d       = ptr_q;
        lk_rdy_d    = 1'b0;
        itlb_miss_d = 1'b0;
        lk_fault_d  = 1'b0;
        lk_ra_d     = lk_ra_q;
        lk_e_d      = lk_e_q;
        lk_i_d      = lk_i_q;
        lk_u0_d     = lk_u0_q;
        fill_req_d  = fill_req_q;
        fill_epn_d  = fill_epn_q;

        case (state_q)
            ST_IDLE: begin
                // An abort in the lookup cycle cancels the lookup outright.
                if (lkValid && !isAbort) begin
                    if (!msrIR) begin
                        lk_rdy_d = 1'b1;
                        lk_ra_d  = RPN_W'(lkEPN);
                        lk_e_d   = realE;
                        lk_i_d   = realI;
                        lk_u0_d  = realU0;
                    end else if (hit) begin
                        lk_rdy_d = 1'b1;
                        lk_ra_d  = merge_ra(rpn_q[hit_idx], lkEPN, size_q[hit_idx]);
                        lk_e_d   = e_q[hit_idx];
                        lk_i_d   = i_q[hit_idx];
                        lk_u0_d  = u0_q[hit_idx];
                    end else begin
                        itlb_miss_d = 1'b1;
                        fill_epn_d  = lkEPN;
                        fill_req_d  = 1'b1;
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // Cancel beats a same-cycle fillAck.
                if (isAbort || isInvalidate) begin
                    fill_req_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (fillAck) begin
                    fill_req_d = 1'b0;
                    if (fillNoMap) begin
                        lk_fault_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        vld_d[victim]  = 1'b1;
                        epn_d[victim]  = fill_epn_q;
                        rpn_d[victim]  = fillRPN;
                        size_d[victim] = fillSize;
                        e_d[victim]    = fillE;
                        i_d[victim]    = fillI;
                        u0_d[victim]   = fillU0;
                        ptr_d          = ptr_q + 1'b1;
                        // Result is staged now and released by REPLAY.
                        lk_ra_d        = merge_ra(fillRPN, fill_epn_q, fillSize);
                        lk_e_d         = fillE;
                        lk_i_d         = fillI;
                        lk_u0_d        = fillU0;
                        state_d        = ST_REPLAY;
                    end
                end
            end
            ST_REPLAY: begin
                lk_rdy_d = !isAbort;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (isInvalidate) begin
            vld_d = '0;
            ptr_d = '0;
        end
    end

    always_ff @(posedge CB) begin
        if (resetCore) begin
            state_q     <= ST_IDLE;
            vld_q       <= '0;
            ptr_q       <= '0;
            lk_rdy_q    <= 1'b0;
            lk_ra_q     <= '0;
            lk_e_q      <= 1'b0;
            lk_i_q      <= 1'b0;
            lk_u0_q     <= 1'b0;
            itlb_miss_q <= 1'b0;
            lk_fault_q  <= 1'b0;
            fill_req_q  <= 1'b0;
            fill_epn_q  <= '0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            ptr_q       <= ptr_d;
            lk_rdy_q    <= lk_rdy_d;
            lk_ra_q     <= lk_ra_d;
            lk_e_q      <= lk_e_d;
            lk_i_q      <= lk_i_d;
            lk_u0_q     <= lk_u0_d;
            itlb_miss_q <= itlb_miss_d;
            lk_fault_q  <= lk_fault_d;
            fill_req_q  <= fill_req_d;
            fill_epn_q  <= fill_epn_d;
        end
        // Entry payload is qualified by vld_q and needs no reset.
        epn_q  <= epn_d;
        rpn_q  <= rpn_d;
        size_q <= size_d;
        e_q    <= e_d;
        i_q    <= i_d;
        u0_q   <= u0_d;
    end

    assign lkBusy   = (state_q != ST_IDLE);
    assign lkRdy    = lk_rdy_q;
    assign lkRA     = lk_ra_q;
    assign lkE      = lk_e_q;
    assign lkI      = lk_i_q;
    assign lkU0     = lk_u0_q;
    assign itlbMiss = itlb_miss_q;
    assign lkFault  = lk_fault_q;
    assign fillReq  = fill_req_q;
    assign fillEPN  = fill_epn_q;

endmodule

// File: tb/tb_p405s_itlb_nway.sv
// Bench for p405s_itlb_nway: directed scenarios then randomized lookups/refills vs a table model.
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after the next rising edge.
// Backpressure: the bench waits for each transaction to finish before issuing the next lookup.
module tb_p405s_itlb_nway;
    localparam int ENTRIES = 4;
    localparam int EPN_W   = 22;
    localparam int RPN_W   = 22;
    localparam int unsigned AMASK = 32'h003F_FFFF;

    localparam int R_MAP   = 0;
    localparam int R_NOMAP = 1;
    localparam int R_ABORT = 2;
    localparam int R_INV   = 3;
    localparam int R_RST   = 4;

    logic CB = 1'b0;
    always #5 CB = ~CB;

    logic             resetCore, lkValid, msrIR, realE, realI, realU0, isAbort, isInvalidate;
    logic [EPN_W-1:0] lkEPN;
    logic             lkBusy, lkRdy, lkE, lkI, lkU0, itlbMiss, lkFault, fillReq;
    logic [RPN_W-1:0] lkRA;
    logic [EPN_W-1:0] fillEPN;
    logic             fillAck, fillNoMap, fillE, fillI, fillU0;
    logic [RPN_W-1:0] fillRPN;
    logic [2:0]       fillSize;

    p405s_itlb_nway #(.ENTRIES(ENTRIES), .EPN_W(EPN_W), .RPN_W(RPN_W)) dut (
        .CB(CB), .resetCore(resetCore), .lkValid(lkValid), .lkEPN(lkEPN), .msrIR(msrIR),
        .realE(realE), .realI(realI), .realU0(realU0), .isAbort(isAbort),
        .isInvalidate(isInvalidate), .lkBusy(lkBusy), .lkRdy(lkRdy), .lkRA(lkRA),
        .lkE(lkE), .lkI(lkI), .lkU0(lkU0), .itlbMiss(itlbMiss), .lkFault(lkFault),
        .fillReq(fillReq), .fillEPN(fillEPN), .fillAck(fillAck), .fillNoMap(fillNoMap),
        .fillE(fillE), .fillI(fillI), .fillU0(fillU0), .fillRPN(fillRPN), .fillSize(fillSize)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference table: one record per entry plus the round-robin pointer.
    bit          m_vld [ENTRIES];
    int unsigned m_epn [ENTRIES];
    int unsigned m_rpn [ENTRIES];
    int          m_sz  [ENTRIES];
    bit [2:0]    m_att [ENTRIES];
    int          m_ptr;

    logic        got_miss, got_fault;
    int unsigned last_ra;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc;
        @(posedge CB);
        #1;
    endtask

    task automatic m_clear;
        for (int k = 0; k < ENTRIES; k++) m_vld[k] = 1'b0;
        m_ptr = 0;
    endtask

    function automatic int m_find(input int unsigned ea);
        for (int k = 0; k < ENTRIES; k++)
            if (m_vld[k] && ((m_epn[k] >> (2 * m_sz[k])) == (ea >> (2 * m_sz[k])))) return k;
        return -1;
    endfunction

    function automatic int unsigned page_ra(input int unsigned rpn, input int unsigned ea, input int sz);
        int unsigned pg;
        pg = 32'd1 << (2 * sz);
        return (((rpn / pg) * pg) + (ea % pg)) & AMASK;
    endfunction

    task automatic chk_result(input string tag, input int unsigned ra, input bit [2:0] att);
        chk({tag, "_rdy"}, lkRdy, 1);
        chk({tag, "_ra"}, lkRA, ra);
        chk({tag, "_att"}, {lkE, lkI, lkU0}, att);
        chk({tag, "_miss"}, itlbMiss, 0);
        last_ra = lkRA;
    endtask

    task automatic lookup(input int unsigned ea_in, input bit ir, input bit inv, input bit abt,
                          input bit [2:0] rl, input int resp, input int unsigned rpn,
                          input int sz, input bit [2:0] fa, input int wait_n);
        int unsigned ea;
        int          hit;
        int          v;
        ea = ea_in & AMASK;
        lkValid = 1; lkEPN = ea[EPN_W-1:0]; msrIR = ir;
        {realE, realI, realU0} = rl;
        isInvalidate = inv; isAbort = abt;
        hit = m_find(ea);
        cyc;
        lkValid = 0; isInvalidate = 0; isAbort = 0;
        if (inv) m_clear();
        got_miss  = itlbMiss;
        got_fault = 1'b0;
        chk("lk_fault", lkFault, 0);
        if (abt) begin
            chk("abt_rdy", lkRdy, 0);
            chk("abt_miss", itlbMiss, 0);
            return;
        end
        if (!ir) begin
            chk_result("real", ea, rl);
            return;
        end
        if (hit >= 0) begin
            chk_result("hit", page_ra(m_rpn[hit], ea, m_sz[hit]), m_att[hit]);
            return;
        end
        chk("miss", itlbMiss, 1);
        chk("miss_rdy", lkRdy, 0);
        chk("miss_busy", lkBusy, 1);
        chk("fill_req", fillReq, 1);
        chk("fill_epn", fillEPN, ea);
        for (int w = 0; w < wait_n; w++) begin
            cyc;
            chk("hold_req", fillReq, 1);
            chk("hold_epn", fillEPN, ea);
            chk("hold_rdy", lkRdy, 0);
        end
        fillRPN = rpn[RPN_W-1:0]; fillSize = 3'(sz); {fillE, fillI, fillU0} = fa;
        case (resp)
            R_MAP: begin
                fillAck = 1; fillNoMap = 0;
                cyc;
                fillAck = 0;
                chk("ack_req", fillReq, 0);
                chk("ack_rdy", lkRdy, 0);
                chk("ack_busy", lkBusy, 1);
                v = m_ptr;
                for (int k = ENTRIES - 1; k >= 0; k--) if (!m_vld[k]) v = k;
                m_vld[v] = 1; m_epn[v] = ea; m_rpn[v] = rpn & AMASK; m_sz[v] = sz; m_att[v] = fa;
                m_ptr = (m_ptr + 1) % ENTRIES;
                cyc;
                chk_result("replay", page_ra(rpn, ea, sz), fa);
                chk("replay_busy", lkBusy, 0);
            end
            R_NOMAP: begin
                fillAck = 1; fillNoMap = 1;
                cyc;
                fillAck = 0; fillNoMap = 0;
                got_fault = lkFault;
                chk("nomap_fault", lkFault, 1);
                chk("nomap_rdy", lkRdy, 0);
                chk("nomap_req", fillReq, 0);
                chk("nomap_busy", lkBusy, 0);
            end
            R_ABORT, R_INV: begin
                fillAck = 1; fillNoMap = 0;
                if (resp == R_ABORT) isAbort = 1; else isInvalidate = 1;
                cyc;
                fillAck = 0; isAbort = 0; isInvalidate = 0;
                if (resp == R_INV) m_clear();
                chk("cancel_req", fillReq, 0);
                chk("cancel_busy", lkBusy, 0);
                chk("cancel_rdy", lkRdy, 0);
                chk("cancel_fault", lkFault, 0);
                cyc;
                chk("cancel_rdy2", lkRdy, 0);
            end
            default: begin
                resetCore = 1; fillAck = 1;
                cyc;
                resetCore = 0; fillAck = 0;
                m_clear();
                chk("rst_req", fillReq, 0);
                chk("rst_busy", lkBusy, 0);
                chk("rst_rdy", lkRdy, 0);
            end
        endcase
    endtask

    task automatic standalone_inv;
        isInvalidate = 1;
        cyc;
        isInvalidate = 0;
        m_clear();
        chk("inv_busy", lkBusy, 0);
    endtask

    initial begin
        resetCore = 1; lkValid = 0; lkEPN = '0; msrIR = 1; realE = 0; realI = 0; realU0 = 0;
        isAbort = 0; isInvalidate = 0; fillAck = 0; fillNoMap = 0; fillE = 0; fillI = 0;
        fillU0 = 0; fillRPN = '0; fillSize = '0;
        m_clear();
        cyc; cyc;
        resetCore = 0;
        chk("rst_busy0", lkBusy, 0);
        chk("rst_rdy0", lkRdy, 0);
        chk("rst_miss0", itlbMiss, 0);
        chk("rst_fault0", lkFault, 0);
        chk("rst_fillreq0", fillReq, 0);
        chk("rst_ra0", lkRA, 0);
        chk("rst_fillepn0", fillEPN, 0);

        // First miss and refill, then an in-page hit on the 16KB page.
        lookup(32'h00123, 1, 0, 0, 3'b000, R_MAP, 32'h3F000, 2, 3'b100, 3);
        chk("d_first_miss", got_miss, 1);
        chk("d_replay_ra", last_ra, 32'h3F003);
        lookup(32'h0012C, 1, 0, 0, 3'b000, R_MAP, 0, 0, 3'b000, 0);
        chk("d_hit_miss", got_miss, 0);
        chk("d_hit_ra", last_ra, 32'h3F00C);

        // Wrap: ENTRIES+1 distinct 1KB pages overwrite entry 0.
        standalone_inv();
        for (int k = 0; k <= ENTRIES; k++)
            lookup((k + 1) * 32'h1000, 1, 0, 0, 3'b000, R_MAP, 32'h20000 + k, 0, 3'b010, 0);
        lookup(32'h2000, 1, 0, 0, 3'b000, R_MAP, 0, 0, 3'b000, 0);
        chk("d_wrap_keep", got_miss, 0);
        lookup(32'h1000, 1, 0, 0, 3'b000, R_MAP, 32'h1111, 0, 3'b001, 0);
        chk("d_wrap_evict", got_miss, 1);

        // Abort racing fillAck leaves nothing behind.
        lookup(32'h05500, 1, 0, 0, 3'b000, R_ABORT, 32'h12345, 0, 3'b111, 1);
        lookup(32'h05500, 1, 0, 0, 3'b000, R_NOMAP, 0, 0, 3'b000, 0);
        chk("d_abort_nowrite", got_miss, 1);

        // Real mode bypass.
        lookup(32'h2AAAA, 0, 0, 0, 3'b010, R_MAP, 0, 0, 3'b000, 0);
        chk("d_real_miss", got_miss, 0);
        chk("d_real_ra", last_ra, 32'h2AAAA);

        // Invalidate after fill; lookup with invalidate sees old contents.
        lookup(32'h07700, 1, 0, 0, 3'b000, R_MAP, 32'h0A000, 1, 3'b011, 0);
        lookup(32'h07701, 1, 1, 0, 3'b000, R_MAP, 0, 0, 3'b000, 0);
        chk("d_inv_sameclk_hit", got_miss, 0);
        lookup(32'h07700, 1, 0, 0, 3'b000, R_NOMAP, 0, 0, 3'b000, 2);
        chk("d_inv_miss", got_miss, 1);
        chk("d_nomap_fault", got_fault, 1);

        // Abort in the lookup cycle, reset mid-refill.
        lookup(32'h09900, 1, 0, 1, 3'b000, R_MAP, 0, 0, 3'b000, 0);
        lookup(32'h09900, 1, 0, 0, 3'b000, R_RST, 32'h1, 0, 3'b000, 1);
        lookup(32'h09900, 1, 0, 0, 3'b000, R_NOMAP, 0, 0, 3'b000, 0);
        chk("d_rst_nowrite", got_miss, 1);

        // Randomized traffic over a small address pool so hits, multi-hits and evictions occur.
        for (int n = 0; n < 400; n++) begin
            int unsigned ea;
            int r, resp;
            ea = ($urandom_range(0, 5) << 8) | $urandom_range(0, 255);
            if ($urandom_range(0, 9) == 0) ea = $urandom;
            r = $urandom_range(0, 19);
            resp = (r < 13) ? R_MAP : (r < 15) ? R_NOMAP : (r < 17) ? R_ABORT : (r < 19) ? R_INV : R_RST;
            if ($urandom_range(0, 29) == 0) standalone_inv();
            lookup(ea, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                   $urandom_range(0, 24) == 0, 3'($urandom), resp, $urandom,
                   $urandom_range(0, 4), 3'($urandom), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/p405s_itlb_nway.md
P405S_ITLB_NWAY -- requirements
Module: p405s_itlb_nway

Interface
REQ-001 SHALL have parameter ENTRIES, default 4: shadow entry count, power of 2, 2..16.
REQ-002 SHALL have parameter EPN_W, default 22: effective page number width (EA bits 0:21).
REQ-003 SHALL have parameter RPN_W, default 22: real page number width.
REQ-004 SHALL have port CB, input, 1: clock; all state on rising edge.
REQ-005 SHALL have port resetCore, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port lkValid, input, 1: lookup request.
REQ-007 SHALL have port lkEPN, input, EPN_W: lookup EPN.
REQ-008 SHALL have port msrIR, input, 1: 1 = translate, 0 = real mode.
REQ-009 SHALL have ports realE, realI, realU0, inputs, 1 each: real-mode attributes.
REQ-010 SHALL have port isAbort, input, 1: cancel outstanding miss.
REQ-011 SHALL have port isInvalidate, input, 1: flash-invalidate all entries.
REQ-012 SHALL have port lkBusy, output, 1: high when not IDLE; lkValid is ignored while high.
REQ-013 SHALL have port lkRdy, output, 1: one-cycle result-valid pulse.
REQ-014 SHALL have ports lkRA (output, RPN_W) and lkE, lkI, lkU0 (outputs, 1 each): translation result, valid only with lkRdy.
REQ-015 SHALL have port itlbMiss, output, 1: one-cycle miss pulse.
REQ-016 SHALL have port lkFault, output, 1: one-cycle pulse, no mapping returned.
REQ-017 SHALL have ports fillReq (output, 1) and fillEPN (output, EPN_W): refill request to the UTLB.
REQ-018 SHALL have ports fillAck, fillNoMap, fillE, fillI, fillU0 (inputs, 1 each), fillRPN (input, RPN_W) and fillSize (input, 3): refill response.

Function
REQ-019 Entry SHALL hold: valid, EPN, RPN, size s (0..7; page = 1KB*4^s), E, I, U0.
REQ-020 Match SHALL be: valid AND the EPN bits above the low 2*s bits are equal.
REQ-021 Hit RA SHALL be: RPN with its low 2*s bits replaced by the lookup EPN low 2*s bits.
REQ-022 Multi-hit SHALL resolve to the lowest index.
REQ-023 FSM SHALL have states IDLE, REQ, REPLAY.
REQ-024 IDLE, lkValid at cycle t:
- Hit: lkRdy at t+1 with RA and attributes.
- Miss: itlbMiss pulse at t+1; EPN captured; state -> REQ.
REQ-025 msrIR=0 SHALL bypass the entries: lkRdy at t+1, lkRA = lkEPN zero-extended/truncated to RPN_W, attributes = real*, never a miss.
REQ-026 REQ SHALL hold fillReq=1 and fillEPN stable until fillAck.
REQ-027 fillAck with fillNoMap=0 SHALL:
- write the entry at the victim pointer;
- advance the pointer mod ENTRIES (wraps ENTRIES-1 -> 0);
- drop fillReq the next cycle;
- go to REPLAY.
REQ-028 REPLAY SHALL pulse lkRdy with the newly written translation one cycle after the fill write, then return to IDLE.
REQ-029 fillAck with fillNoMap=1 SHALL pulse lkFault next cycle, write nothing, and return to IDLE.
REQ-030 isAbort in REQ SHALL drop fillReq next cycle and return to IDLE with no fill; abort and fillAck in the same cycle SHALL resolve as abort wins.
REQ-031 isAbort in IDLE or REPLAY SHALL suppress that cycle's lkRdy/itlbMiss output pulses.
REQ-032 isInvalidate SHALL clear all valid bits next cycle and reset the victim pointer to 0.
REQ-033 isInvalidate in REQ SHALL behave as an abort.
REQ-034 isInvalidate together with a lookup SHALL be evaluated against the pre-invalidate contents.
REQ-035 Victim choice SHALL prefer the lowest invalid entry; otherwise it SHALL use the round-robin pointer.
REQ-036 lkRdy, itlbMiss and lkFault SHALL be mutually exclusive.

Reset
REQ-037 On resetCore all valid bits, the victim pointer and all outputs SHALL be 0 and the state SHALL be IDLE.
REQ-038 resetCore mid-REQ SHALL drop fillReq next cycle, with no fill.
REQ-039 resetCore SHALL have priority over every other input.

Verification
REQ-040 Reset, then lkValid with EPN=0x00123, msrIR=1 -> itlbMiss at t+1, fillReq=1 with fillEPN=0x00123 held until ack.
REQ-041 fillAck with RPN=0x3F000, size=2, E=1 -> REPLAY lkRdy with lkRA=0x3F003, lkE=1; a later lookup of 0x0012C hits with RA 0x3F00C.
REQ-042 Fill ENTRIES+1 distinct pages -> entry 0 is replaced (wrap); the first page then misses.
REQ-043 isAbort asserted in the same cycle as fillAck -> no write, no lkRdy, state IDLE next cycle.
REQ-044 msrIR=0 lookup of 0x2AAAA with realI=1 -> lkRdy at t+1, lkRA=0x2AAAA, lkI=1, no itlbMiss.
REQ-045 isInvalidate after a fill -> a subsequent same-EPN lookup misses; fillNoMap=1 -> lkFault pulse.
